fifo_top_black_box: RTL and testbench



---
 rtl/fifo_pkg.sv | 19 +
 rtl/sync_fifo_core.sv | 82 ++++++++
 rtl/fifo_top_black_box.sv | 65 ++++++
 tb/tb_fifo_top_black_box.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// fifo_pkg : default geometry and read-rate constants for the FIFO wrapper
// Revision : 1.0
// ============================================================================
package fifo_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int ADDR_WIDTH_DEF = 4;
    localparam int AF_THRESH_DEF  = 14;
    localparam int RD_DIV_DEF     = 2;

    // Divider counter width; a divide-by-one still needs a 1-bit register.
    function automatic int div_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo_core.sv
`default_nettype none
// ============================================================================
// sync_fifo_core : single-clock FIFO storage, pointers, occupancy and flags
// Revision : 1.0
// ============================================================================
module sync_fifo_core
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int AF_THRESH  = AF_THRESH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_req,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_tick,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   count
);

    localparam int                DEPTH   = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AF_THRESH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wptr;
    logic [ADDR_WIDTH-1:0] rptr;
    logic [ADDR_WIDTH:0]   count_nxt;
    logic                  do_wr;
    logic                  do_rd;

    // Both decisions use the pre-edge count: a read cannot free a slot for a
    // write on the same edge, and a write cannot feed a read on the same edge.
    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);
    assign do_wr = wr_req & ~full;
    assign do_rd = rd_tick & ~empty;

    always_comb begin
        count_nxt = count;
        case ({do_wr, do_rd})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr        <= '0;
            rptr        <= '0;
            count       <= '0;
            rd_data     <= '0;
            rd_valid    <= 1'b0;
            almost_full <= 1'b0;
        end else begin
            count       <= count_nxt;
            almost_full <= (count_nxt >= AF_C);
            rd_valid    <= do_rd;
            if (do_wr) begin
                wptr <= wptr + 1'b1;
            end
            if (do_rd) begin
                rd_data <= mem[rptr];
                rptr    <= rptr + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fifo_top_black_box.sv
`default_nettype none
// ============================================================================
// fifo_top_black_box : FIFO wrapper draining one word every RD_DIV clocks
// Revision : 1.0
// ============================================================================
module fifo_top_black_box
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int AF_THRESH  = AF_THRESH_DEF,
    parameter int RD_DIV     = RD_DIV_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_input,
    input  logic [DATA_WIDTH-1:0] from_user,
    output logic [DATA_WIDTH-1:0] to_the_user,
    output logic                  rvalid,
    output logic                  almost_full
);

    localparam int DIV_W = div_width(RD_DIV);

    logic [DIV_W-1:0]    divider;
    logic                rd_tick;
    logic                full;
    logic                empty;
    logic                wen;
    logic [ADDR_WIDTH:0] count;

    // Models the slower consumer: one read opportunity per RD_DIV clocks.
    assign rd_tick = (divider == DIV_W'(RD_DIV - 1));
    assign wen     = ~full;

    always_ff @(posedge clk) begin
        if (rst) begin
            divider <= '0;
        end else if (rd_tick) begin
            divider <= '0;
        end else begin
            divider <= divider + 1'b1;
        end
    end

    sync_fifo_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .AF_THRESH  (AF_THRESH)
    ) u_core (
        .clk         (clk),
        .rst         (rst),
        .wr_req      (valid_input),
        .wr_data     (from_user),
        .rd_tick     (rd_tick),
        .rd_data     (to_the_user),
        .rd_valid    (rvalid),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .count       (count)
    );

endmodule
`default_nettype wire

// File: tb/tb_fifo_top_black_box.sv
`default_nettype none
// ============================================================================
// tb_fifo_top_black_box : randomized bench with a queue-based FIFO model
// Revision : 1.0
// ============================================================================
module tb_fifo_top_black_box;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       vin  [2];
    logic [7:0] din  [2];
    logic [7:0] dout [2];
    logic       rv   [2];
    logic       af   [2];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int ec [2];
    logic [7:0]  mq     [2][$];
    logic [31:0] exp_ev [2][$];
    logic [31:0] obs_ev [2][$];

    always #5 clk = ~clk;

    fifo_top_black_box #(.RD_DIV(2)) dut0 (
        .clk(clk), .rst(rst), .valid_input(vin[0]), .from_user(din[0]),
        .to_the_user(dout[0]), .rvalid(rv[0]), .almost_full(af[0])
    );

    fifo_top_black_box #(.RD_DIV(1000)) dut1 (
        .clk(clk), .rst(rst), .valid_input(vin[1]), .from_user(din[1]),
        .to_the_user(dout[1]), .rvalid(rv[1]), .almost_full(af[1])
    );

    function automatic int div_of(input int k);
        return (k == 0) ? 2 : 1000;
    endfunction

    // Advance one clock: the model decides reads/writes from the occupancy
    // before the edge; reads happen on every RD_DIV-th edge after reset.
    task automatic tick();
        int pre;
        cyc++;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                mq[k].delete();
                ec[k] = 0;
            end else begin
                pre = mq[k].size();
                ec[k]++;
                if ((ec[k] % div_of(k)) == 0 && pre > 0)
                    exp_ev[k].push_back({cyc[23:0], mq[k].pop_front()});
                if (vin[k] && pre < 16)
                    mq[k].push_back(din[k]);
            end
        end
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++)
            if (rv[k]) obs_ev[k].push_back({cyc[23:0], dout[k]});
    endtask

    task automatic clear_ev();
        for (int k = 0; k < 2; k++) begin
            exp_ev[k].delete();
            obs_ev[k].delete();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_ev();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (rv[k] !== 1'b0) begin
                errors++; $display("FAIL reset_rvalid%0d got %b want 0", k, rv[k]);
            end
            checks++;
            if (dout[k] !== 8'h00) begin
                errors++; $display("FAIL reset_data%0d got %h want 00", k, dout[k]);
            end
            checks++;
            if (af[k] !== 1'b0) begin
                errors++; $display("FAIL reset_af%0d got %b want 0", k, af[k]);
            end
        end
        checks++;
        if (dut0.wen !== 1'b1 || dut0.full !== 1'b0 || dut0.empty !== 1'b1) begin
            errors++;
            $display("FAIL reset_flags got wen=%b full=%b empty=%b want 1 0 1",
                     dut0.wen, dut0.full, dut0.empty);
        end
        clear_ev();
    endtask

    task automatic test_single_word();
        int wcyc;
        do_reset();
        vin[0] = 1'b1;
        din[0] = 8'h01;
        tick();
        wcyc = cyc;
        vin[0] = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        checks++;
        if (obs_ev[0].size() != 1) begin
            errors++; $display("FAIL single_pulses got %0d want 1", obs_ev[0].size());
        end else begin
            checks++;
            if (obs_ev[0][0][7:0] !== 8'h01) begin
                errors++; $display("FAIL single_data got %h want 01", obs_ev[0][0][7:0]);
            end
            checks++;
            if (int'(obs_ev[0][0][31:8]) - wcyc > 3) begin
                errors++;
                $display("FAIL single_latency got %0d edges want <=3",
                         int'(obs_ev[0][0][31:8]) - wcyc);
            end
        end
        checks++;
        if (dut0.empty !== 1'b1) begin
            errors++; $display("FAIL single_empty got %b want 1", dut0.empty);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] in_q [$];
        int sent   = 0;
        int guard  = 0;
        bit saw_af = 1'b0;
        do_reset();
        while (sent < 50 && guard < 1000) begin
            if (dut0.wen && !af[0]) begin
                vin[0] = 1'b1;
                din[0] = 8'($urandom);
                in_q.push_back(din[0]);
                sent++;
            end else begin
                vin[0] = 1'b0;
            end
            tick();
            guard++;
            if (af[0]) saw_af = 1'b1;
            checks++;
            if (af[0] !== (mq[0].size() >= 14)) begin
                errors++;
                $display("FAIL b2b_af cyc %0d got %b want %b", cyc, af[0], mq[0].size() >= 14);
            end
            checks++;
            if (int'(dut0.count) != mq[0].size()) begin
                errors++;
                $display("FAIL b2b_count cyc %0d got %0d want %0d", cyc, dut0.count, mq[0].size());
            end
        end
        vin[0] = 1'b0;
        for (int i = 0; i < 80; i++) tick();
        checks++;
        if (sent != 50) begin
            errors++; $display("FAIL b2b_sent got %0d want 50", sent);
        end
        checks++;
        if (!saw_af) begin
            errors++; $display("FAIL b2b_af_seen got 0 want 1");
        end
        checks++;
        if (obs_ev[0].size() != in_q.size() || exp_ev[0].size() != in_q.size()) begin
            errors++;
            $display("FAIL b2b_words got %0d model %0d want %0d",
                     obs_ev[0].size(), exp_ev[0].size(), in_q.size());
        end
        for (int i = 0; i < in_q.size() && i < obs_ev[0].size() && i < exp_ev[0].size(); i++) begin
            checks++;
            if (obs_ev[0][i] !== exp_ev[0][i] || obs_ev[0][i][7:0] !== in_q[i]) begin
                errors++;
                $display("FAIL b2b_word%0d got %h want %h (data %h)",
                         i, obs_ev[0][i], exp_ev[0][i], in_q[i]);
            end
        end
    endtask

    task automatic test_overflow();
        logic [7:0] wr [$];
        int guard = 0;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            vin[1] = 1'b1;
            din[1] = 8'($urandom);
            wr.push_back(din[1]);
            tick();
            if (i == 14) begin
                checks++;
                if (dut1.full !== 1'b0) begin
                    errors++; $display("FAIL ovf_full15 got %b want 0", dut1.full);
                end
            end
            if (i == 15) begin
                checks++;
                if (dut1.full !== 1'b1) begin
                    errors++; $display("FAIL ovf_full16 got %b want 1", dut1.full);
                end
            end
        end
        vin[1] = 1'b0;
        checks++;
        if (dut1.count !== 5'd16) begin
            errors++; $display("FAIL ovf_count got %0d want 16", dut1.count);
        end
        while (obs_ev[1].size() < 16 && guard < 16100) begin
            tick();
            guard++;
        end
        for (int i = 0; i < 20; i++) tick();
        checks++;
        if (obs_ev[1].size() != 16) begin
            errors++; $display("FAIL ovf_words got %0d want 16", obs_ev[1].size());
        end
        for (int i = 0; i < 16 && i < obs_ev[1].size() && i < exp_ev[1].size(); i++) begin
            checks++;
            if (obs_ev[1][i] !== exp_ev[1][i] || obs_ev[1][i][7:0] !== wr[i]) begin
                errors++;
                $display("FAIL ovf_word%0d got %h want %h (data %h)",
                         i, obs_ev[1][i], exp_ev[1][i], wr[i]);
            end
        end
        checks++;
        if (dut1.empty !== 1'b1) begin
            errors++; $display("FAIL ovf_empty got %b want 1", dut1.empty);
        end
    endtask

    task automatic test_full_rw();
        do_reset();
        vin[1] = 1'b1;
        for (int i = 0; i < 1003; i++) begin
            din[1] = 8'($urandom);
            tick();
            checks++;
            if (int'(dut1.count) != mq[1].size() || dut1.full !== (mq[1].size() == 16)) begin
                errors++;
                $display("FAIL fullrw_state cyc %0d got cnt=%0d full=%b want %0d",
                         cyc, dut1.count, dut1.full, mq[1].size());
            end
            if (ec[1] == 1000) begin
                checks++;
                if (dut1.count !== 5'd15) begin
                    errors++; $display("FAIL fullrw_rd_edge got %0d want 15", dut1.count);
                end
            end
            if (ec[1] == 1001) begin
                checks++;
                if (dut1.count !== 5'd16) begin
                    errors++; $display("FAIL fullrw_next_edge got %0d want 16", dut1.count);
                end
            end
        end
        vin[1] = 1'b0;
        checks++;
        if (obs_ev[1].size() != 1 || exp_ev[1].size() != 1 || obs_ev[1][0] !== exp_ev[1][0]) begin
            errors++;
            $display("FAIL fullrw_read got %0d words want 1 matching model", obs_ev[1].size());
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        vin[1] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            din[1] = 8'($urandom);
            tick();
        end
        vin[1] = 1'b0;
        checks++;
        if (dut1.count !== 5'd5) begin
            errors++; $display("FAIL mid_queued got %0d want 5", dut1.count);
        end
        do_reset();
        for (int i = 0; i < 2100; i++) tick();
        checks++;
        if (obs_ev[1].size() != 0) begin
            errors++; $display("FAIL mid_rvalid got %0d pulses want 0", obs_ev[1].size());
        end
        checks++;
        if (dut1.count !== 5'd0 || dut1.empty !== 1'b1) begin
            errors++;
            $display("FAIL mid_count got cnt=%0d empty=%b want 0 1", dut1.count, dut1.empty);
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            vin[k] = 1'b0;
            din[k] = 8'h00;
            ec[k]  = 0;
        end
        @(negedge clk);
        test_reset();
        test_single_word();
        test_back_to_back();
        test_overflow();
        test_full_rw();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
